// File: rtl/mul_nterm_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_nterm_seq
// Purpose  : Sequential product of a selected subset of NTERMS signed
//            WIDTH-bit terms. A single WIDTHxWIDTH signed multiplier is
//            stepped over one term index per cycle. Unselected terms count
//            as 1. Each partial product either wraps or saturates, chosen per
//            transaction. A sticky overflow flag records any partial product
//            that does not fit, and a zero partial product ends the
//            iteration early.
// Ports    : clk, n_reset          - clock / async active-low reset
//            in_valid, in_ready    - request handshake
//            terms, sel, sat       - request payload (sampled on accept)
//            out_valid, out_ready  - result handshake
//            result, overflow      - signed product and overflow flag
//            busy                  - high while computing or presenting
// Revision : 1.0 - initial release
// ============================================================================
module mul_nterm_seq #(
  parameter int WIDTH  = 8,
  parameter int NTERMS = 3
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NTERMS*WIDTH-1:0] terms,
  input  logic [NTERMS-1:0]       sel,
  input  logic                    sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    overflow,
  output logic                    busy
);

  localparam int IDXW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam int NPAD = 2 ** IDXW;

  localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NTERMS - 1);
  localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]       A_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]       A_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]       A_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state, state_n;
  logic [WIDTH-1:0]          acc, acc_n;
  logic [IDXW-1:0]           idx, idx_n;
  logic                      ovf, ovf_n;
  logic [NTERMS*WIDTH-1:0]   terms_q, terms_n;
  logic [NTERMS-1:0]         sel_q, sel_n;
  logic                      sat_q, sat_n;
  logic [WIDTH-1:0]          result_q, result_n;
  logic                      overflow_q, overflow_n;

  // Term/select tables padded to a power of two so idx never indexes past
  // the end, whatever NTERMS is.
  logic [WIDTH-1:0]          term_tab [NPAD];
  logic [NPAD-1:0]           sel_tab;

  for (genvar i = 0; i < NPAD; i++) begin : g_tab
    if (i < NTERMS) begin : g_real
      assign term_tab[i] = terms_q[i*WIDTH +: WIDTH];
      assign sel_tab[i]  = sel_q[i];
    end else begin : g_pad
      assign term_tab[i] = '0;
      assign sel_tab[i]  = 1'b0;
    end
  end

  logic [WIDTH-1:0]          cur_term;
  logic                      cur_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic                      prod_ovf;
  logic [WIDTH-1:0]          step_val;

  assign cur_term = term_tab[idx];
  assign cur_sel  = sel_tab[idx];

  // Full-width product from sign-extended operands, so no bits are lost.
  assign prod = $signed({{WIDTH{acc[WIDTH-1]}}, acc}) *
                $signed({{WIDTH{cur_term[WIDTH-1]}}, cur_term});

  assign prod_ovf = (prod > P_MAX) || (prod < P_MIN);

  always_comb begin
    step_val = prod[WIDTH-1:0];
    if (sat_q && prod_ovf) begin
      step_val = prod[2*WIDTH-1] ? A_MIN : A_MAX;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      acc        <= A_ONE;
      idx        <= '0;
      ovf        <= 1'b0;
      terms_q    <= '0;
      sel_q      <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      idx        <= idx_n;
      ovf        <= ovf_n;
      terms_q    <= terms_n;
      sel_q      <= sel_n;
      sat_q      <= sat_n;
      result_q   <= result_n;
      overflow_q <= overflow_n;
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    idx_n      = idx;
    ovf_n      = ovf;
    terms_n    = terms_q;
    sel_n      = sel_q;
    sat_n      = sat_q;
    result_n   = result_q;
    overflow_n = overflow_q;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          terms_n = terms;
          sel_n   = sel;
          sat_n   = sat;
          acc_n   = A_ONE;
          idx_n   = '0;
          ovf_n   = 1'b0;
          state_n = S_MUL;
        end
      end
      S_MUL: begin
        if (cur_sel) begin
          acc_n = step_val;
          ovf_n = ovf | prod_ovf;
        end
        idx_n = idx + IDXW'(1);
        // Only a selected update can produce the zero that ends early; an
        // unselected zero term leaves acc alone.
        if ((idx == LAST_IDX) || (cur_sel && (step_val == '0))) begin
          state_n    = S_DONE;
          result_n   = acc_n;
          overflow_n = ovf_n;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // in_ready is gated by the reset pin so it drops immediately on assertion.
  assign in_ready  = (state == S_IDLE) && n_reset;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_nterm_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_nterm_seq
// Purpose  : Self-checking bench for mul_nterm_seq (WIDTH=8, NTERMS=3).
//            Expected result/overflow/latency come from a behavioural model
//            and are queued when a request is driven. They are popped and
//            compared when the DUT presents its result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_nterm_seq;

  localparam int W = 8;
  localparam int N = 3;

  logic           clk;
  logic           n_reset;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] terms;
  logic [N-1:0]   sel;
  logic           sat;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           overflow;
  logic           busy;

  typedef struct {
    int res;
    int ovf;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  mul_nterm_seq #(.WIDTH(W), .NTERMS(N)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .terms    (terms),
    .sel      (sel),
    .sat      (sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int c, input int b, input int a);
    logic [W-1:0] cc, bb, aa;
    cc = c[W-1:0];
    bb = b[W-1:0];
    aa = a[W-1:0];
    return {cc, bb, aa};
  endfunction

  function automatic exp_t model(input logic [N*W-1:0] t, input logic [N-1:0] s,
                                 input logic st);
    exp_t         e;
    int           acc;
    int           p;
    int           tv;
    logic [W-1:0] lo;
    logic [W-1:0] tb;
    acc   = 1;
    e.ovf = 0;
    e.lat = N;
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        tb = t[i*W +: W];
        tv = $signed(tb);
        p  = acc * tv;
        if (p > 127 || p < -128) e.ovf = 1;
        if (st) begin
          acc = (p > 127) ? 127 : ((p < -128) ? -128 : p);
        end else begin
          lo  = p[W-1:0];
          acc = $signed(lo);
        end
        if (acc == 0) begin
          e.lat = i + 1;
          break;
        end
      end
    end
    e.res = acc;
    return e;
  endfunction

  // One full transaction: hold = cycles of backpressure once result appears.
  task automatic run_txn(input string tag, input logic [N*W-1:0] t,
                         input logic [N-1:0] s, input logic st, input int hold);
    exp_t e;
    int   cyc;
    int   r0;
    int   o0;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".ready"}, int'(in_ready), 1);
    sb.push_back(model(t, s, st));
    terms     = t;
    sel       = s;
    sat       = st;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    terms    = $urandom();
    sel      = $urandom();
    sat      = $urandom();
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, ".valid"}, int'(out_valid), 1);
    check({tag, ".lat"}, cyc, e.lat);
    check({tag, ".res"}, int'($signed(result)), e.res);
    check({tag, ".ovf"}, int'(overflow), e.ovf);
    if (hold > 0) begin
      r0 = int'($signed(result));
      o0 = int'(overflow);
      for (int k = 0; k < hold; k++) begin
        in_valid = k[0];
        @(posedge clk); #1;
        check({tag, ".hold_v"}, int'(out_valid), 1);
        check({tag, ".hold_r"}, int'($signed(result)), r0);
        check({tag, ".hold_o"}, int'(overflow), o0);
        check({tag, ".hold_rdy"}, int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".idle_v"}, int'(out_valid), 0);
    check({tag, ".idle_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    terms     = '0;
    sel       = '0;
    sat       = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst.in_ready", int'(in_ready), 0);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.result", int'(result), 0);
    check("rst.overflow", int'(overflow), 0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;

    run_txn("c1", pack(5, -4, 3), 3'b111, 1'b0, 0);
    run_txn("c2w", pack(2, 100, 1), 3'b110, 1'b0, 0);
    run_txn("c2s", pack(2, 100, 1), 3'b110, 1'b1, 0);
    run_txn("c3s", pack(-1, 1, -128), 3'b101, 1'b1, 0);
    run_txn("c3w", pack(-1, 1, -128), 3'b101, 1'b0, 0);
    run_txn("c3z", pack(-1, 1, -128), 3'b000, 1'b0, 0);
    run_txn("c4e", pack(7, 9, 0), 3'b111, 1'b0, 0);
    run_txn("c4n", pack(7, 9, 0), 3'b110, 1'b0, 0);
    run_txn("c5", pack(2, 100, 1), 3'b110, 1'b1, 5);
    run_txn("c5b", pack(5, -4, 3), 3'b111, 1'b0, 0);

    // Reset in the middle of MUL, after the first processing edge.
    terms    = pack(5, -4, 3);
    sel      = 3'b111;
    sat      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("c6.busy_pre", int'(busy), 1);
    n_reset = 1'b0;
    #1;
    check("c6.in_ready", int'(in_ready), 0);
    check("c6.out_valid", int'(out_valid), 0);
    check("c6.busy", int'(busy), 0);
    check("c6.result", int'(result), 0);
    check("c6.overflow", int'(overflow), 0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    check("c6.rdy_rel", int'(in_ready), 1);
    @(posedge clk); #1;
    run_txn("c6f", pack(5, -4, 3), 3'b111, 1'b0, 0);

    for (int j = 0; j < 8; j++) begin
      run_txn("rnd", N*W'($urandom()), N'($urandom()), 1'($urandom()),
              int'($urandom_range(0, 2)));
    end

    check("sb.empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
